// File: rtl/blake2s_host_drv.sv
// blake2s_host_drv: host-side initiator for the byte-serial BLAKE2s command interface.
// Sends a job's CONF header (kk, nn, ll little endian), streams key/message bytes as DATA,
// zero-pads to whole blocks, then collects the nn-byte digest.
// Ports:
//   clk, nreset            clock, async active-low reset
//   start_i, kk_i, nn_i,   job start and parameters (sampled when idle)
//   ll_i
//   msg_v_i, msg_i,        user byte stream in, accepted on msg_v_i & msg_ready_o
//   msg_ready_o
//   busy_o, done_o         job in progress, 1-cycle completion pulse
//   dev_valid_o, dev_cmd_o, dev_data_o, dev_ready_i   device command byte handshake
//   dev_hash_v_i, dev_hash_i                           digest bytes from device
//   hash_v_o, hash_o, hash_idx_o                       registered digest bytes with index
// Build option: define HOST_DRV_ABORT_EN to add abort_i, which replaces the pending slot
// with a single ABORT command (cmd 2'd3, data 8'h00) and returns to idle without done_o.
module blake2s_host_drv #(
  parameter int BLOCK_BYTES = 64,
  parameter int LL_W = 64
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            start_i,
  input  logic [5:0]      kk_i,
  input  logic [5:0]      nn_i,
  input  logic [LL_W-1:0] ll_i,
  input  logic            msg_v_i,
  input  logic [7:0]      msg_i,
  output logic            msg_ready_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            dev_valid_o,
  output logic [1:0]      dev_cmd_o,
  output logic [7:0]      dev_data_o,
  input  logic            dev_ready_i,
  input  logic            dev_hash_v_i,
  input  logic [7:0]      dev_hash_i,
`ifdef HOST_DRV_ABORT_EN
  input  logic            abort_i,
`endif
  output logic            hash_v_o,
  output logic [7:0]      hash_o,
  output logic [5:0]      hash_idx_o
);
  localparam int CW = LL_W + 7;
  localparam int BW = $clog2(BLOCK_BYTES);
  localparam int CONF_LAST = 1 + LL_W / 8;

  typedef enum logic [2:0] {IDLE, CONF, KEY, MSG, PAD, WAIT_HASH, ABORT} state_t;

  state_t          state_q, state_d;
  logic [5:0]      kk_q, kk_d, nn_q, nn_d, hidx_q, hidx_d;
  logic [LL_W-1:0] ll_q, ll_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic            dv_q, dv_d, hv_q, hv_d, done_q, done_d;
  logic [1:0]      dc_q, dc_d;
  logic [7:0]      dd_q, dd_d, h_q, h_d, ll_byte, conf_byte;
  logic            free, take, ll_hit, blk_hit, abort;

`ifdef HOST_DRV_ABORT_EN
  assign abort = abort_i && state_q != IDLE && state_q != ABORT;
`else
  assign abort = 1'b0;
`endif

  // CONF header: kk, nn, then ll bytes least significant first (header index 2..CONF_LAST)
  assign ll_byte   = 8'(ll_q >> {cnt_q[5:0] - 6'd2, 3'b000});
  assign conf_byte = cnt_q == '0 ? {2'b00, kk_q} : cnt_q == CW'(1) ? {2'b00, nn_q} : ll_byte;

  always_comb begin
    free = !dv_q || dev_ready_i;
    cnt_inc = cnt_q + CW'(1);
    ll_hit = cnt_inc == CW'(ll_q);
    blk_hit = cnt_inc[BW-1:0] == '0;
    msg_ready_o = (state_q == KEY || state_q == MSG) && free && !abort;
    take = msg_ready_o && msg_v_i;
    state_d = state_q;
    kk_d = kk_q;
    nn_d = nn_q;
    ll_d = ll_q;
    cnt_d = cnt_q;
    dv_d = dv_q && !dev_ready_i;
    dc_d = dc_q;
    dd_d = dd_q;
    hv_d = 1'b0;
    h_d = h_q;
    hidx_d = hidx_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (start_i && !done_q) begin
        kk_d = kk_i;
        nn_d = nn_i == '0 ? 6'd1 : nn_i;
        ll_d = ll_i;
        cnt_d = '0;
        state_d = CONF;
      end
      CONF: if (free) begin
        dv_d = 1'b1;
        dc_d = 2'd0;
        dd_d = conf_byte;
        cnt_d = cnt_q == CW'(CONF_LAST) ? '0 : cnt_inc;
        if (cnt_q == CW'(CONF_LAST)) state_d = kk_q != '0 ? KEY : ll_q != '0 ? MSG : PAD;
      end
      KEY: if (take) begin
        dv_d = 1'b1;
        dc_d = 2'd1;
        dd_d = msg_i;
        cnt_d = cnt_inc == CW'(BLOCK_BYTES) ? '0 : cnt_inc;
        if (cnt_inc == CW'(BLOCK_BYTES)) state_d = ll_q != '0 ? MSG : WAIT_HASH;
      end
      // message count keeps running into PAD so padding stops on the next block boundary
      MSG: if (take) begin
        dv_d = 1'b1;
        dc_d = 2'd1;
        dd_d = msg_i;
        cnt_d = ll_hit && blk_hit ? '0 : cnt_inc;
        if (ll_hit) state_d = blk_hit ? WAIT_HASH : PAD;
      end
      PAD: if (free) begin
        dv_d = 1'b1;
        dc_d = 2'd1;
        dd_d = 8'h00;
        cnt_d = blk_hit ? '0 : cnt_inc;
        if (blk_hit) state_d = WAIT_HASH;
      end
      WAIT_HASH: if (dev_hash_v_i) begin
        hv_d = 1'b1;
        h_d = dev_hash_i;
        hidx_d = cnt_q[5:0];
        cnt_d = cnt_q[5:0] == nn_q - 6'd1 ? '0 : cnt_inc;
        done_d = cnt_q[5:0] == nn_q - 6'd1;
        if (cnt_q[5:0] == nn_q - 6'd1) state_d = IDLE;
      end
      ABORT: if (dev_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      dv_d = 1'b1;
      dc_d = 2'd3;
      dd_d = 8'h00;
      cnt_d = '0;
      hv_d = 1'b0;
      done_d = 1'b0;
      state_d = ABORT;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      kk_q <= '0;
      nn_q <= '0;
      ll_q <= '0;
      cnt_q <= '0;
      dv_q <= 1'b0;
      dc_q <= '0;
      dd_q <= '0;
      hv_q <= 1'b0;
      h_q <= '0;
      hidx_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      kk_q <= kk_d;
      nn_q <= nn_d;
      ll_q <= ll_d;
      cnt_q <= cnt_d;
      dv_q <= dv_d;
      dc_q <= dc_d;
      dd_q <= dd_d;
      hv_q <= hv_d;
      h_q <= h_d;
      hidx_q <= hidx_d;
      done_q <= done_d;
    end
  end

  // done_o coincides with the last digest byte while state is already IDLE, so busy covers it
  assign busy_o      = state_q != IDLE || done_q;
  assign done_o      = done_q;
  assign dev_valid_o = dv_q;
  assign dev_cmd_o   = dc_q;
  assign dev_data_o  = dd_q;
  assign hash_v_o    = hv_q;
  assign hash_o      = h_q;
  assign hash_idx_o  = hidx_q;
endmodule
